// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage pipelined MIPS CPU.
// Owns the PC, the instruction-memory request handshake and the IF/ID register.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   stall             load-use stall from control; holds PC and IF/ID
//   branch_taken      taken branch/jump resolved in ID
//   branch_target     redirect PC, valid with branch_taken
//   imem_req          fetch request
//   imem_addr         fetch address (always equal to pc)
//   imem_rdata        fetched word, valid with imem_ack
//   imem_ack          one-cycle completion strobe
//   pc                current fetch PC
//   if_instr          word entering ID on the next edge (load-use look-ahead)
//   id_instr, id_pc4  IF/ID instruction and PC+4
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | first cycle out of reset, no request issued, ID gets a bubble
// FETCH | request outstanding at pc, waiting for imem_ack
// HELD  | word fetched during a stall, parked in fetch_buf until release

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] if_instr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc_nx;
  logic [31:0] id_instr_nx;
  logic [31:0] id_pc4_nx;
  logic [31:0] fetch_buf, fetch_buf_nx;
  logic        redir_pend, redir_pend_nx;
  logic [31:0] redir_pc, redir_pc_nx;
  logic [31:0] pc_plus4;

  // 32-bit modulo: 32'hFFFF_FFFC wraps to 0.
  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      id_instr   <= NOP_INSTR;
      id_pc4     <= 32'h0000_0000;
      fetch_buf  <= 32'h0000_0000;
      redir_pend <= 1'b0;
      redir_pc   <= 32'h0000_0000;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      id_instr   <= id_instr_nx;
      id_pc4     <= id_pc4_nx;
      fetch_buf  <= fetch_buf_nx;
      redir_pend <= redir_pend_nx;
      redir_pc   <= redir_pc_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    id_instr_nx   = id_instr;
    id_pc4_nx     = id_pc4;
    fetch_buf_nx  = fetch_buf;
    redir_pend_nx = redir_pend;
    redir_pc_nx   = redir_pc;
    imem_req      = 1'b0;
    if_instr      = NOP_INSTR;

    unique case (state)
      BOOT: begin
        id_instr_nx = NOP_INSTR;
        state_nx    = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack && !redir_pend)
          if_instr = imem_rdata;

        if (!imem_ack) begin
          // Waiting: ID sees bubbles. A redirect arriving now is a one-cycle
          // pulse, so it is remembered and applied when the request completes.
          if (!stall) begin
            id_instr_nx = NOP_INSTR;
            if (branch_taken) begin
              redir_pend_nx = 1'b1;
              redir_pc_nx   = branch_target;
            end
          end
        end else if (redir_pend) begin
          // Word belongs to the wrong path; drop it and jump.
          pc_nx         = redir_pc;
          redir_pend_nx = 1'b0;
          if (!stall)
            id_instr_nx = NOP_INSTR;
        end else if (stall) begin
          fetch_buf_nx = imem_rdata;
          state_nx     = HELD;
        end else if (branch_taken) begin
          id_instr_nx = NOP_INSTR;
          id_pc4_nx   = pc_plus4;
          pc_nx       = branch_target;
        end else begin
          id_instr_nx = imem_rdata;
          id_pc4_nx   = pc_plus4;
          pc_nx       = pc_plus4;
        end
      end

      HELD: begin
        if_instr = fetch_buf;
        if (!stall) begin
          id_pc4_nx = pc_plus4;
          state_nx  = FETCH;
          if (branch_taken) begin
            id_instr_nx = NOP_INSTR;
            pc_nx       = branch_target;
          end else begin
            id_instr_nx = fetch_buf;
            pc_nx       = pc_plus4;
          end
        end
      end

      default: begin
        state_nx = BOOT;
      end
    endcase
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc;
  logic [31:0] if_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc(pc), .if_instr(if_instr),
    .id_instr(id_instr), .id_pc4(id_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks what the fetch unit owns in pipeline terms
  // (a fresh-out-of-reset bubble, a word parked behind a stall, a redirect
  // owed once the outstanding fetch returns).
  logic [31:0] m_pc, m_id_instr, m_id_pc4, m_park_word, m_redir_pc;
  bit          m_fresh, m_parked, m_redir;

  function automatic void model_reset();
    m_pc = 32'h0; m_id_instr = NOP; m_id_pc4 = 32'h0;
    m_park_word = 32'h0; m_redir_pc = 32'h0;
    m_fresh = 1; m_parked = 0; m_redir = 0;
  endfunction

  function automatic bit exp_req();
    return !m_fresh && !m_parked;
  endfunction

  function automatic logic [31:0] exp_if_instr();
    if (m_fresh) return NOP;
    if (m_parked) return m_park_word;
    return (imem_ack && !m_redir) ? imem_rdata : NOP;
  endfunction

  function automatic void model_step();
    logic [31:0] next_seq;
    next_seq = m_pc + 32'd4;
    if (m_fresh) begin
      m_fresh = 0;
      m_id_instr = NOP;
    end else if (m_parked) begin
      if (!stall) begin
        m_id_instr = branch_taken ? NOP : m_park_word;
        m_id_pc4   = next_seq;
        m_pc       = branch_taken ? branch_target : next_seq;
        m_parked   = 0;
      end
    end else if (!imem_ack) begin
      if (!stall) begin
        m_id_instr = NOP;
        if (branch_taken) begin
          m_redir = 1;
          m_redir_pc = branch_target;
        end
      end
    end else if (m_redir) begin
      m_pc = m_redir_pc;
      m_redir = 0;
      if (!stall) m_id_instr = NOP;
    end else if (stall) begin
      m_parked = 1;
      m_park_word = imem_rdata;
    end else begin
      m_id_instr = branch_taken ? NOP : imem_rdata;
      m_id_pc4   = next_seq;
      m_pc       = branch_taken ? branch_target : next_seq;
    end
  endfunction

  task automatic drive(input bit s, input bit b, input logic [31:0] t,
                       input bit a, input logic [31:0] d);
    stall = s; branch_taken = b; branch_target = t; imem_ack = a; imem_rdata = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    n_checks++;
    if (id_instr !== NOP || id_pc4 !== 32'h0) begin
      n_fail++; $display("FAIL reset_ifid got=%h/%h exp=%h/%h", id_instr, id_pc4, NOP, 32'h0);
    end
    n_checks++;
    if (if_instr !== NOP) begin n_fail++; $display("FAIL reset_if_instr got=%h exp=%h", if_instr, NOP); end
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc4;
    n_checks++;
    if (imem_req !== 1'b1 || id_instr !== NOP) begin
      n_fail++; $display("FAIL boot_exit req=%b id=%h exp req=1 id=%h", imem_req, id_instr, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 1, 32'h2001_0005);
      tick();
      exp_pc4 = 32'd4 * (i + 1);
      n_checks++;
      if (id_instr !== 32'h2001_0005 || id_pc4 !== exp_pc4) begin
        n_fail++; $display("FAIL seq_fetch%0d got=%h/%h exp=%h/%h", i, id_instr, id_pc4, 32'h2001_0005, exp_pc4);
      end
    end
    n_checks++;
    if (pc !== 32'd12) begin n_fail++; $display("FAIL seq_pc got=%h exp=%h", pc, 32'd12); end
    drive(0, 0, 32'h0, 1, 32'h1111_0000);
    tick();
  endtask

  task automatic test_stall_held();
    drive(1, 0, 32'h0, 1, 32'hABCD_0010);
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (imem_req !== 1'b0 || pc !== 32'h10 || id_instr !== 32'h1111_0000 || if_instr !== 32'hABCD_0010) begin
        n_fail++;
        $display("FAIL held%0d req=%b pc=%h id=%h if=%h exp req=0 pc=10 id=11110000 if=abcd0010",
                 i, imem_req, pc, id_instr, if_instr);
      end
      drive(i == 0, 0, 32'h0, 0, 32'h0);
      if (i == 0) tick();
    end
    tick();
    n_checks++;
    if (id_instr !== 32'hABCD_0010 || id_pc4 !== 32'h14 || pc !== 32'h14 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL held_release id=%h pc4=%h pc=%h req=%b exp abcd0010/14/14/1", id_instr, id_pc4, pc, imem_req);
    end
    drive(0, 0, 32'h0, 1, 32'h2222_0014);
    tick();
  endtask

  task automatic test_branch();
    drive(0, 1, 32'h40, 1, 32'h3333_0018);
    n_checks++;
    if (pc !== 32'h18) begin n_fail++; $display("FAIL branch_pre_pc got=%h exp=18", pc); end
    tick();
    n_checks++;
    if (id_instr !== NOP || id_pc4 !== 32'h1C || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL branch id=%h pc4=%h addr=%h exp %h/1c/40", id_instr, id_pc4, imem_addr, NOP);
    end
  endtask

  task automatic test_delayed_redirect();
    drive(0, 1, 32'h80, 0, 32'h0);
    tick();
    n_checks++;
    if (id_instr !== NOP || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL wait1 id=%h addr=%h exp %h/40", id_instr, imem_addr, NOP);
    end
    drive(0, 0, 32'h0, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 1, 32'h4444_0040);
    n_checks++;
    if (if_instr !== NOP) begin n_fail++; $display("FAIL late_word_if got=%h exp=%h", if_instr, NOP); end
    tick();
    n_checks++;
    if (id_instr !== NOP || imem_addr !== 32'h80 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL redirect id=%h addr=%h req=%b exp %h/80/1", id_instr, imem_addr, imem_req, NOP);
    end
  endtask

  task automatic test_stall_branch();
    drive(1, 1, 32'hC0, 1, 32'h5555_0080);
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || pc !== 32'h80) begin
      n_fail++; $display("FAIL stall_branch_hold req=%b pc=%h exp 0/80", imem_req, pc);
    end
    drive(0, 1, 32'hC0, 0, 32'h0);
    tick();
    n_checks++;
    if (id_instr !== NOP || id_pc4 !== 32'h84 || pc !== 32'hC0) begin
      n_fail++; $display("FAIL stall_branch_release id=%h pc4=%h pc=%h exp %h/84/c0", id_instr, id_pc4, pc, NOP);
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 32'hFFFF_FFFC, 1, 32'h0);
    tick();
    drive(0, 0, 32'h0, 1, 32'h6666_FFFC);
    tick();
    n_checks++;
    if (pc !== 32'h0 || id_pc4 !== 32'h0 || id_instr !== 32'h6666_FFFC) begin
      n_fail++; $display("FAIL wrap pc=%h pc4=%h id=%h exp 0/0/6666fffc", pc, id_pc4, id_instr);
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(0, 0, 32'h0, 1, 32'h7777_0000);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    tick();
    #2;
    rst = 1'b0;
    imem_ack = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (pc !== 32'h0 || id_instr !== NOP || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_wait pc=%h id=%h req=%b exp 0/%h/0", pc, id_instr, imem_req, NOP);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom,
            $urandom_range(0, 2) != 0, $urandom);
      n_checks++;
      if (pc !== m_pc || imem_addr !== m_pc || imem_req !== exp_req() || if_instr !== exp_if_instr() ||
          id_instr !== m_id_instr || id_pc4 !== m_id_pc4) begin
        n_fail++;
        $display("FAIL random%0d got pc=%h req=%b if=%h id=%h pc4=%h exp pc=%h req=%b if=%h id=%h pc4=%h",
                 i, pc, imem_req, if_instr, id_instr, id_pc4, m_pc, exp_req(), exp_if_instr(), m_id_instr, m_id_pc4);
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall_held();
    test_branch();
    test_delayed_redirect();
    test_stall_branch();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS CPU, directly upstream of the decode/control stage.
- Owns the PC, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the control unit's load-use stall and taken-branch/jump redirect; produces the decode instruction and the look-ahead fetch instruction used for load-use detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, bubble word (sll $0,$0,0) inserted on squash/wait

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
stall  in  1  load-use stall from control (cu_wpcir); 1 = hold PC and IF/ID
branch_taken  in  1  taken branch/j/jal/jr resolved in ID (cu_branch)
branch_target  in  32  redirect PC, valid when branch_taken=1
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_rdata  in  32  fetched word, valid when imem_ack=1
imem_ack  in  1  one-cycle completion strobe
pc  out  32  current fetch PC
if_instr  out  32  word entering ID next edge (look-ahead for load-use check)
id_instr  out  32  IF/ID instruction register
id_pc4  out  32  IF/ID PC+4 (jal link, branch base)

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, id_instr=NOP_INSTR, id_pc4=0, buf=0, redir_pend=0, redir_pc=0, state=BOOT, imem_req=0.
- States: BOOT, FETCH, HELD.
- BOOT: imem_req=0, if_instr=NOP_INSTR. Next edge -> FETCH; IF/ID loads NOP.
- FETCH: imem_req=1, imem_addr=pc. Address stays stable until ack; a request is never aborted.
- FETCH, ack=1, stall=0, branch_taken=0, redir_pend=0:
  - IF/ID <= {imem_rdata, pc+4}; pc <= pc+4.
- FETCH, ack=1, stall=0, branch_taken=1:
  - IF/ID <= {NOP_INSTR, pc+4}, squashing the fetched word (no delay slot).
  - pc <= branch_target.
- FETCH, ack=1, redir_pend=1:
  - Word discarded; IF/ID <= NOP (if stall=0); pc <= redir_pc; redir_pend <= 0.
- FETCH, ack=1, stall=1, redir_pend=0:
  - buf <= imem_rdata; pc holds; IF/ID holds; -> HELD.
- FETCH, ack=0:
  - pc holds; IF/ID <= NOP if stall=0, else IF/ID holds.
  - If branch_taken=1 and stall=0: redir_pend <= 1, redir_pc <= branch_target (the one-cycle pulse must not be lost).
- HELD: imem_req=0.
  - stall=1: hold everything.
  - stall=0, branch_taken=0: IF/ID <= {buf, pc+4}; pc <= pc+4; -> FETCH.
  - stall=0, branch_taken=1: IF/ID <= {NOP, pc+4}; pc <= branch_target; -> FETCH.
- stall=1 has priority over branch_taken in all states: the branch stays in ID and is re-resolved the next cycle.
- if_instr (combinational):
  - FETCH: imem_ack && !redir_pend ? imem_rdata : NOP_INSTR.
  - HELD: buf.
  - BOOT: NOP_INSTR.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. branch_target is used unaligned-as-is; bits [1:0] are not checked.
- imem_ack while imem_req=0 is ignored.
- Reset asserted mid-request: immediate return to reset values. The memory must drop any pending transaction; an ack during reset is ignored.

Test Plan:
- Reset, then ack every cycle with rdata=0x2001_0005 at pc 0,4,8 -> id_instr sequence NOP, 0x20010005 x3; id_pc4=4,8,12; pc=12 after 3 fetches.
- stall=1 for 2 cycles with ack on pc=0x10 -> state HELD, imem_req=0, id_instr/pc frozen, if_instr=buf. Release -> id_instr=buf, pc=0x14.
- branch_taken=1, target=0x40 with ack at pc=0x18 -> id_instr=NOP, id_pc4=0x1C, next imem_addr=0x40.
- ack delayed 3 cycles; branch_taken pulse (target 0x80) in wait cycle 1 -> id_instr NOP every cycle, late word discarded, next imem_addr=0x80.
- Simultaneous stall=1 and branch_taken=1 with ack -> no redirect, HELD; next cycle stall=0, branch_taken=1 -> NOP into ID, pc=target.
- pc=0xFFFF_FFFC, ack, no branch -> pc=0, id_pc4=0. Also rst=0 mid-wait -> pc=RESET_PC and id_instr=NOP immediately, imem_req=0.
